pdm_modulator: RTL and testbench
================================

Name: pdm_modulator

Overview:
- Upstream stimulus/source stage for Filter: converts 8-bit PCM samples into the 1-bit pulse-density stream that Filter consumes on IN, one bit per CLK.
- First-order error-feedback (accumulator carry) modulator.
- Each accepted sample is held for OSR clocks.
- Small input FIFO with valid/ready handshake decouples the sample producer from the fixed bit rate.

Parameters:
- DW, 8, PCM sample width; unsigned offset binary, midscale = 2^(DW-1).
- OSR, 64, clocks per PCM sample (oversampling ratio); must be >= 2.
- DEPTH, 4, input FIFO entries; power of two, >= 2.

Ports:
- CLK  input  1  single system clock; all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- IN_DATA  input  DW  PCM sample.
- IN_VALID  input  1  IN_DATA valid this cycle.
- IN_READY  output  1  FIFO can accept; IN_READY = (level != DEPTH).
- OUT  output  1  registered PDM bit; connects to Filter IN.
- SAMPLE_TICK  output  1  one-cycle pulse (registered) on the edge a new held sample is loaded.
- LEVEL  output  clog2(DEPTH)+1  current FIFO occupancy.
- UNDERRUN  output  1  sticky; set when a sample was needed and the FIFO was empty after priming.

Behaviour:
- Reset values (RST low, asynchronous):
  - OUT=0, SAMPLE_TICK=0, LEVEL=0, UNDERRUN=0.
  - acc=0, phase=0, cur=2^(DW-1) (midscale), primed=0.
  - FIFO contents discarded.
- Reset mid-operation has the same effect at any time; no partial sample survives.
- Modulator, every CLK edge:
  - sum = acc + cur (DW+1 bits).
  - OUT <= sum[DW]; acc <= sum[DW-1:0].
- Bit density equals cur/2^DW exactly. Over any 2^DW consecutive clocks with constant cur, OUT has exactly cur ones.
- Phase counter:
  - phase counts 0..OSR-1, then wraps to 0.
  - On the edge where phase==OSR-1:
    - FIFO non-empty: pop head into cur, primed<=1, SAMPLE_TICK<=1.
    - FIFO empty and primed=1: cur unchanged (repeat last sample), UNDERRUN<=1, SAMPLE_TICK<=1.
    - FIFO empty and primed=0: cur stays midscale, no UNDERRUN, SAMPLE_TICK<=1.
  - SAMPLE_TICK=0 on all other edges.
- Latency:
  - A sample loaded on wrap edge N first affects the sum on edge N+1; it appears in OUT from after edge N+1.
  - First pop after reset occurs on the edge ending clock OSR-1 (the OSR-th edge).
- FIFO:
  - Push when IN_VALID && IN_READY; pop on a wrap edge when non-empty.
  - Push and pop on the same edge: level unchanged, data order preserved.
  - Full (level==DEPTH) with a same-edge pop: IN_READY is still 0 that cycle; the push is refused and the producer must hold.
  - Empty with a same-edge push: the new word is not popped that edge; the wrap takes the empty path.
  - Pointers wrap modulo DEPTH.
- Arithmetic is unsigned throughout; no saturation needed. cur=0 gives a constant 0; cur=2^DW-1 gives 2^DW-1 ones per 2^DW clocks.
- UNDERRUN clears only on reset.

Test Plan:
- Reset release, no input, 1000 clocks:
  - OUT = 0,1,0,1,… starting 0 after the first edge.
  - SAMPLE_TICK pulses every 64 clocks.
  - UNDERRUN=0, LEVEL=0.
- Push 0xFF x4, then count OUT ones over 256 clocks starting one edge after the first SAMPLE_TICK that loads 0xFF -> exactly 255 ones.
- Push 0x00 x4 -> from one edge after the load, OUT=0 for all 256 clocks.
- Push 0x40 then 0xC0:
  - OUT ones over 256 clocks at 0x40 = 64.
  - Switch occurs exactly 64 clocks after the first load.
- Hold IN_VALID with 6 distinct samples during phase 0..10:
  - 4 accepted, IN_READY=0, LEVEL=4.
  - On the next wrap edge LEVEL=3 but the push is refused; the 5th sample is accepted on the following cycle.
  - Pop order matches push order.
- Push one 0x40, wait two wraps:
  - UNDERRUN=1 on the second wrap edge.
  - OUT keeps density 64/256.
  - Async RST low between edges -> OUT, LEVEL, UNDERRUN=0 immediately; after release, alternating 0,1 pattern resumes.

Source files
------------

// File: rtl/pdm_modulator_if.sv
// Sample-producer handshake into the PDM modulator's input FIFO.
interface pdm_modulator_if #(
    parameter int DW = 8
);
    logic [DW-1:0] IN_DATA;
    logic          IN_VALID;
    logic          IN_READY;

    modport master (output IN_DATA, output IN_VALID, input IN_READY);
    modport slave  (input IN_DATA, input IN_VALID, output IN_READY);
endinterface

// File: rtl/pdm_modulator.sv
// First-order PCM-to-PDM modulator (accumulator carry) with a small input FIFO;
// each sample is held for OSR clocks, repeating the last one if the FIFO runs dry.
module pdm_modulator #(
    parameter int DW    = 8,
    parameter int OSR   = 64,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    pdm_modulator_if.slave           in_if,
    output logic                     OUT,
    output logic                     SAMPLE_TICK,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     UNDERRUN
);
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int PHW = $clog2(OSR);
    localparam logic [DW-1:0] MIDSCALE = DW'(1) << (DW - 1);

    logic [DW-1:0]  mem_q [DEPTH];
    logic [DW-1:0]  mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [PHW-1:0] phase_q, phase_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic [DW-1:0]  cur_q, cur_d;
    logic           primed_q, primed_d;
    logic           out_q, out_d;
    logic           tick_q, tick_d;
    logic           underrun_q, underrun_d;

    logic [DW:0]    sum;
    logic           wrap;
    logic           empty;
    logic           ready;
    logic           push;
    logic           pop;

    assign sum   = {1'b0, acc_q} + {1'b0, cur_q};
    assign wrap  = (phase_q == PHW'(OSR - 1));
    assign empty = (level_q == '0);
    assign ready = (level_q != LW'(DEPTH));
    assign push  = in_if.IN_VALID && ready;
    // A word pushed into an empty FIFO on a wrap edge is not yet visible to pop.
    assign pop   = wrap && !empty;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        phase_d    = wrap ? '0 : phase_q + PHW'(1);
        acc_d      = sum[DW-1:0];
        out_d      = sum[DW];
        cur_d      = cur_q;
        primed_d   = primed_q;
        tick_d     = wrap;
        underrun_d = underrun_q | (wrap && empty && primed_q);

        if (push) begin
            mem_d[wr_ptr_q] = in_if.IN_DATA;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            cur_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
            primed_d = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
            cur_q      <= MIDSCALE;
            primed_q   <= 1'b0;
            out_q      <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            primed_q   <= primed_d;
            out_q      <= out_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_if.IN_READY = ready;
    assign OUT            = out_q;
    assign SAMPLE_TICK    = tick_q;
    assign LEVEL          = level_q;
    assign UNDERRUN       = underrun_q;
endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: hand-computed OUT densities, tick timing,
// FIFO back-pressure, underrun and asynchronous reset behaviour.
module tb_pdm_modulator;
    logic       CLK;
    logic       RST;
    logic       OUT;
    logic       tick;
    logic [2:0] level;
    logic       underrun;

    int vectors;
    int miscompares;
    int ecnt;
    int ones;
    int idx;
    int win [6];
    logic rdy;
    logic [7:0] samp [6];

    pdm_modulator_if #(.DW(8)) bus ();

    pdm_modulator #(.DW(8), .OSR(64), .DEPTH(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_if       (bus),
        .OUT         (OUT),
        .SAMPLE_TICK (tick),
        .LEVEL       (level),
        .UNDERRUN    (underrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every step ends half a period after a rising edge; ecnt = edges since reset release.
    task automatic next();
        @(negedge CLK);
        ecnt++;
    endtask

    task automatic run_to(input int n);
        while (ecnt < n) next();
    endtask

    task automatic count_ones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            next();
            cnt += int'(OUT);
        end
    endtask

    task automatic push_n(input logic [7:0] d, input int n);
        bus.IN_DATA  = d;
        bus.IN_VALID = 1'b1;
        repeat (n) next();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        bus.IN_VALID = 1'b0;
        #2 RST = 1'b0;
        #1;
        chk({tag, "_out"},      int'(OUT),      0);
        chk({tag, "_level"},    int'(level),    0);
        chk({tag, "_underrun"}, int'(underrun), 0);
        chk({tag, "_tick"},     int'(tick),     0);
        @(negedge CLK);
        RST  = 1'b1;
        ecnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        ecnt         = 0;
        RST          = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 8'h00;
        samp = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        // Reset values and 1000 idle clocks at midscale
        #3;
        chk("por_out",      int'(OUT),      0);
        chk("por_tick",     int'(tick),     0);
        chk("por_level",    int'(level),    0);
        chk("por_underrun", int'(underrun), 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (1000) begin
            next();
            chk("idle_out",  int'(OUT),  int'(ecnt % 2 == 0));
            chk("idle_tick", int'(tick), int'(ecnt % 64 == 0));
            if (ecnt % 64 == 0) chk("idle_underrun", int'(underrun), 0);
        end
        chk("idle_level", int'(level), 0);
        chk("idle_ready", int'(bus.IN_READY), 1);

        // 0xFF x4: 255 ones in 256 clocks after the load
        apply_reset("rst_ff");
        push_n(8'hFF, 4);
        chk("ff_level_full", int'(level), 4);
        chk("ff_ready_full", int'(bus.IN_READY), 0);
        run_to(64);
        chk("ff_tick",      int'(tick),  1);
        chk("ff_level_pop", int'(level), 3);
        count_ones(256, ones);
        chk("ff_ones", ones, 255);

        // 0x00 x4: silent
        apply_reset("rst_00");
        push_n(8'h00, 4);
        run_to(64);
        count_ones(256, ones);
        chk("zero_ones", ones, 0);

        // 0x40 x4: 64 ones in 256 clocks
        apply_reset("rst_40");
        push_n(8'h40, 4);
        run_to(64);
        count_ones(256, ones);
        chk("q40_ones", ones, 64);

        // 0x40 then 0xC0: switch lands exactly one OSR period after the first load
        apply_reset("rst_sw");
        push_n(8'h40, 1);
        push_n(8'hC0, 1);
        run_to(64);
        count_ones(64, ones);
        chk("sw_ones_40", ones, 16);
        chk("sw_tick", int'(tick), 1);
        next();
        chk("sw_out129", int'(OUT), 0);
        next();
        chk("sw_out130", int'(OUT), 1);
        count_ones(62, ones);
        chk("sw_ones_c0", ones, 47);

        // Back-pressure with six held samples; per-window densities prove pop order
        apply_reset("rst_bp");
        for (int i = 0; i < 6; i++) win[i] = 0;
        idx          = 0;
        bus.IN_DATA  = samp[0];
        bus.IN_VALID = 1'b1;
        repeat (448) begin
            rdy = bus.IN_READY && bus.IN_VALID;
            next();
            if (rdy) begin
                idx++;
                if (idx < 6) bus.IN_DATA = samp[idx];
                else bus.IN_VALID = 1'b0;
            end
            if (ecnt > 64) win[(ecnt - 65) / 64] += int'(OUT);
            if (ecnt == 4) begin
                chk("bp_level4", int'(level), 4);
                chk("bp_ready4", int'(bus.IN_READY), 0);
                chk("bp_idx4",   idx, 4);
            end
            if (ecnt == 63) chk("bp_ready63", int'(bus.IN_READY), 0);
            if (ecnt == 64) begin
                chk("bp_level64", int'(level), 3);
                chk("bp_idx64",   idx, 4);
            end
            if (ecnt == 65) begin
                chk("bp_level65", int'(level), 4);
                chk("bp_idx65",   idx, 5);
            end
            if (ecnt == 129) chk("bp_idx129", idx, 6);
        end
        for (int i = 0; i < 6; i++) chk($sformatf("bp_win%0d", i), win[i], int'(samp[i]) / 4);

        // Single sample then underrun; reset mid-run clears everything
        apply_reset("rst_ur");
        push_n(8'h40, 1);
        run_to(127);
        chk("ur_before", int'(underrun), 0);
        next();
        chk("ur_set",  int'(underrun), 1);
        chk("ur_tick", int'(tick),     1);
        count_ones(256, ones);
        chk("ur_ones", ones, 64);
        chk("ur_pre_reset_out", int'(OUT), 1);
        apply_reset("rst_mid");
        repeat (8) begin
            next();
            chk("post_rst_out", int'(OUT), int'(ecnt % 2 == 0));
        end
        chk("post_rst_underrun", int'(underrun), 0);

        // Push into an empty FIFO on the wrap edge: not popped, no underrun
        apply_reset("rst_ep");
        run_to(63);
        bus.IN_DATA  = 8'h00;
        bus.IN_VALID = 1'b1;
        next();
        bus.IN_VALID = 1'b0;
        chk("ep_level",    int'(level),    1);
        chk("ep_tick",     int'(tick),     1);
        chk("ep_underrun", int'(underrun), 0);
        run_to(66);
        chk("ep_out66", int'(OUT), 1);
        run_to(128);
        chk("ep_level_pop", int'(level), 0);
        run_to(130);
        chk("ep_out130", int'(OUT), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
